debounce_edge_detect: RTL and testbench



---
 rtl/sync_chain.sv | 29 ++
 rtl/debounce_edge_detect.sv | 87 ++++++++
 tb/tb_debounce_edge_detect.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sync_chain.sv
// Reusable flip-flop synchronizer for a single asynchronous input bit.
// Pure register chain: nothing sits between stages so every stage has a
// full clock period to resolve metastability.
module sync_chain #(
  parameter int STAGES      = 2,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg_q, stg_d;

  // Shift the raw input into stage 0 and move every stage one step along.
  always_comb begin
    stg_d = {stg_q[STAGES-2:0], d};
  end

  // Chain registers; reset loads the idle level into every stage.
  always_ff @(posedge clk) begin
    if (reset) stg_q <= {STAGES{RESET_LEVEL}};
    else       stg_q <= stg_d;
  end

  assign q = stg_q[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Debouncer with registered edge pulses: synchronizer -> stability counter
// -> registered level and rise/fall detector.
// q only moves after the synchronized input has disagreed with it for
// STABLE_CYCLES consecutive edges; any return to q restarts the count.
module debounce_edge_detect #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = ($clog2(STABLE_CYCLES + 1) < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

  // Out-of-range parameters stop elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("debounce_edge_detect: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("debounce_edge_detect: STABLE_CYCLES must be 1..255");
  end

  logic             sync;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_LEVEL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (sync)
  );

  // Count consecutive disagreements; accept the new level at terminal count.
  // Clearing at terminal count means the counter can never wrap.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync != level_q) begin
      if (cnt_q == TERM) begin
        level_d = sync;
        cnt_d   = '0;
        rise_d  = sync;
        fall_d  = ~sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; reset wins over a terminal count on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = sync ^ level_q;

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect at default parameters.
module tb_debounce_edge_detect;

  localparam int SS = 2;
  localparam int ST = 8;
  localparam bit RL = 1'b0;

  logic clk = 1'b0;
  logic reset, d;
  logic q, rise, fall, busy;

  int checks = 0;
  int errors = 0;

  debounce_edge_detect #(
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (ST),
    .RESET_LEVEL   (RL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: the synchronizer is a plain delay line of d; q changes
  // when the last ST synchronized samples taken since the previous change
  // (or reset) all disagree with q.
  logic dl [SS];
  logic win [$];
  logic m_q, m_rise, m_fall;

  function automatic logic m_busy();
    return dl[SS-1] != m_q;
  endfunction

  task automatic model_step(input logic r, input logic din);
    logic s;
    bit all_diff;
    if (r) begin
      for (int i = 0; i < SS; i++) dl[i] = RL;
      m_q = RL; m_rise = 1'b0; m_fall = 1'b0;
      win.delete();
    end else begin
      s = dl[SS-1];
      for (int i = SS-1; i > 0; i--) dl[i] = dl[i-1];
      dl[0] = din;
      win.push_back(s);
      if (win.size() > ST) void'(win.pop_front());
      m_rise = 1'b0; m_fall = 1'b0;
      all_diff = (win.size() == ST);
      foreach (win[i]) if (win[i] == m_q) all_diff = 1'b0;
      if (all_diff) begin
        m_q = s; m_rise = s; m_fall = ~s;
        win.delete();
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare all outputs after the edge.
  task automatic tick(input logic r, input logic din);
    reset = r; d = din;
    @(posedge clk);
    model_step(r, din);
    #1;
    chk("model_q", q, m_q);
    chk("model_rise", rise, m_rise);
    chk("model_fall", fall, m_fall);
    chk("model_busy", busy, m_busy());
    chk("rise_fall_exclusive", rise & fall, 1'b0);
  endtask

  typedef struct {
    logic r, din;
    logic eq, erise, efall, ebusy;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(logic r, logic din, logic eq, logic er, logic ef, logic eb);
    vec_t v;
    v.r = r; v.din = din; v.eq = eq; v.erise = er; v.efall = ef; v.ebusy = eb;
    return v;
  endfunction

  int pulses, toggles, n;
  bit seen;
  logic q0;

  initial begin
    reset = 1'b1; d = 1'b1;

    // Reset held 3 edges with d=1, clean rise, then clean fall.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int e = 1; e <= 11; e++)
      vecs.push_back(mk(0, 1, e >= 10, e == 10, 0, (e >= 2 && e <= 9)));
    for (int e = 1; e <= 11; e++)
      vecs.push_back(mk(0, 0, e < 10, 0, e == 10, (e >= 2 && e <= 9)));

    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].din);
      chk("vec_q", q, vecs[i].eq);
      chk("vec_rise", rise, vecs[i].erise);
      chk("vec_fall", fall, vecs[i].efall);
      chk("vec_busy", busy, vecs[i].ebusy);
    end

    // Glitch: 5 cycles high then low again must not move q.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(0, 1); pulses += rise + fall; end
    for (int i = 0; i < 12; i++) begin tick(0, 0); pulses += rise + fall; end
    chk("glitch_no_pulse", pulses == 0, 1'b1);
    chk("glitch_q", q, 1'b0);
    chk("glitch_busy_idle", busy, 1'b0);

    // Reset on edge 6 of a count; rise only 10 edges after release.
    for (int i = 1; i <= 5; i++) tick(0, 1);
    tick(1, 1);
    chk("midreset_q", q, 1'b0);
    n = 0; seen = 0;
    while (!seen && n < 30) begin
      tick(0, 1); n++;
      if (rise) seen = 1;
      else chk("midreset_early_q", q, 1'b0);
    end
    chk("midreset_rise_seen", seen, 1'b1);
    chk("midreset_latency10", n == 10, 1'b1);
    for (int i = 0; i < 12; i++) tick(0, 0);

    // Chatter with period 7: q stays put, no pulses.
    pulses = 0; q0 = q;
    for (int i = 0; i < 100; i++) begin
      tick(0, ((i / 7) % 2) == 1);
      pulses += rise + fall;
      chk("chatter7_q", q, q0);
    end
    chk("chatter7_no_pulse", pulses == 0, 1'b1);
    for (int i = 0; i < 12; i++) tick(0, 0);

    // Period 9: one pulse per d transition.
    pulses = 0; toggles = 0;
    for (int i = 0; i < 100; i++) begin
      if (i > 0 && (i % 9) == 0) toggles++;
      tick(0, ((i / 9) % 2) == 1);
      pulses += rise + fall;
    end
    for (int i = 0; i < 12; i++) begin
      tick(0, ((99 / 9) % 2) == 1);
      pulses += rise + fall;
    end
    chk("chatter9_pulse_count", pulses == toggles, 1'b1);

    // Random held levels of varied length, with occasional resets.
    for (int s = 0; s < 150; s++) begin
      logic lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      if ($urandom_range(0, 49) == 0) tick(1, lvl);
      for (int i = 0; i < len; i++) tick(0, lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
